// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serialiser, with zero-gap back-to-back frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 521,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       tx_clk,
  input  logic       tx_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    hold;
  logic          hold_full;
  logic          par_bit;
  logic          baud_last;
  logic          stop_end;
  logic          load;

  function automatic logic par_of(input logic [7:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  assign baud_last = (baud_cnt == BAUD_MAX);
  assign stop_end  = (state == S_STOP) && baud_last
                   && (bit_idx == STOP_MAX);
  assign load      = hold_full
                   && ((state == S_IDLE) || stop_end);
  assign tx_ready  = ~hold_full;
  assign tx_busy   = (state != S_IDLE);

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      tx_out    <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // load needs hold_full, accept needs !hold_full: never both
      if (load) begin
        hold_full <= 1'b0;
        shreg     <= hold;
        par_bit   <= par_of(hold);
      end else if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (load) begin
            state  <= S_START;
            tx_out <= 1'b0;
          end else begin
            tx_out <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx_out   <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state  <= S_PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_out  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx_out   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_MAX) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              if (load) begin
                state  <= S_START;
                tx_out <= 1'b0;
              end else begin
                state  <= S_IDLE;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances cover 8N1 at 521 and 4
// clocks/bit, even parity with 2 stops, and odd parity at 2 clocks/bit.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      vld;
  logic [3:0]      rdy;
  logic [3:0]      txo;
  logic [3:0]      bsy;
  logic [3:0]      dn;
  logic [3:0][7:0] dat;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] src[$];
  int acc_q[$];
  int fall_q[$];
  int done_q[$];
  int wait_q[$];

  uart_tx #(.CLKS_PER_BIT(521), .PARITY(0), .STOP_BITS(1)) u_521 (
    .tx_clk(clk), .tx_rst_n(rst_n), .tx_data(dat[0]),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_out(txo[0]),
    .tx_busy(bsy[0]), .tx_done(dn[0]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_4 (
    .tx_clk(clk), .tx_rst_n(rst_n), .tx_data(dat[1]),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_out(txo[1]),
    .tx_busy(bsy[1]), .tx_done(dn[1]));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_e2 (
    .tx_clk(clk), .tx_rst_n(rst_n), .tx_data(dat[2]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_out(txo[2]),
    .tx_busy(bsy[2]), .tx_done(dn[2]));

  uart_tx #(.CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(1)) u_o1 (
    .tx_clk(clk), .tx_rst_n(rst_n), .tx_data(dat[3]),
    .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_out(txo[3]),
    .tx_busy(bsy[3]), .tx_done(dn[3]));

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  task automatic clear();
    exp_q.delete();
    src.delete();
    acc_q.delete();
    fall_q.delete();
    done_q.delete();
    wait_q.delete();
  endtask

  // Offer each byte of src with valid held; junk mode scrambles data
  // whenever the DUT is not ready.
  task automatic drive(int i, bit junk);
    int wd;
    foreach (src[k]) begin
      vld[i] = 1'b1;
      wd = 0;
      if (junk) dat[i] = 8'h99;
      while (rdy[i] !== 1'b1 && wd < 20000) begin
        @(negedge clk);
        wd++;
        if (junk) dat[i] = 8'h99;
      end
      if (rdy[i] !== 1'b1) begin
        chk("drv_timeout", wd, -1);
        vld[i] = 1'b0;
        return;
      end
      dat[i] = src[k];
      acc_q.push_back(cyc + 1);
      wait_q.push_back(wd);
      exp_q.push_back(src[k]);
      @(negedge clk);
    end
    vld[i] = 1'b0;
    dat[i] = 8'h99;
  endtask

  task automatic mon(int i, int n, int cpb, int par, int stops);
    int nb, wd, st, bz;
    logic v;
    logic [7:0] d, e;
    nb = 9 + ((par != 0) ? 1 : 0) + stops;
    for (int f = 0; f < n; f++) begin
      wd = 0;
      while (txo[i] !== 1'b0 && wd < 20000) begin
        @(negedge clk);
        wd++;
      end
      if (txo[i] !== 1'b0) begin
        chk("mon_timeout", wd, -1);
        return;
      end
      fall_q.push_back(cyc);
      chk("exp_avail", int'(exp_q.size() > 0), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      d = '0;
      bz = 0;
      for (int p = 0; p < nb; p++) begin
        v = txo[i];
        st = 1;
        for (int c = 0; c < cpb; c++) begin
          if (txo[i] !== v) st = 0;
          bz += int'(bsy[i]);
          @(negedge clk);
        end
        chk("bit_stable", st, 1);
        if (p == 0) chk("start_bit", int'(v), 0);
        else if (p <= 8) d[p-1] = v;
        else if (par != 0 && p == 9)
          chk("parity", int'(v), (par == 2) ? int'(^e) : int'(~^e));
        else chk("stop_bit", int'(v), 1);
      end
      chk("data", int'(d), int'(e));
      chk("done_pulse", int'(dn[i]), 1);
      done_q.push_back(cyc);
      chk("busy_cycles", bz, nb * cpb);
    end
  endtask

  initial begin
    int target, bad;
    rst_n = 1'b0;
    vld   = '0;
    dat   = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_out", int'(txo[i]), 1);
      chk("rst_ready", int'(rdy[i]), 1);
      chk("rst_busy", int'(bsy[i]), 0);
      chk("rst_done", int'(dn[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 at 521 clocks/bit from idle
    clear();
    src.push_back(8'hE3);
    fork
      drive(0, 1'b0);
      mon(0, 1, 521, 0, 1);
    join
    chk("fall_latency", fall_q[0] - acc_q[0], 1);
    chk("frame_521", done_q[0] - fall_q[0], 5210);
    chk("idle_after", int'(bsy[0]), 0);

    clear();
    src.push_back(8'h00);
    src.push_back(8'hFF);
    fork
      drive(0, 1'b0);
      mon(0, 2, 521, 0, 1);
    join
    chk("gap_521", fall_q[1] - done_q[0], 0);

    // back-to-back at 4 clocks/bit
    clear();
    src.push_back(8'h55);
    src.push_back(8'hAA);
    fork
      drive(1, 1'b0);
      mon(1, 2, 4, 0, 1);
    join
    chk("ready_low", wait_q[1], 1);
    chk("start_spacing", fall_q[1] - fall_q[0], 40);
    chk("done_spacing", done_q[1] - done_q[0], 40);
    chk("zero_gap", fall_q[1] - done_q[0], 0);
    chk("b2b_total", done_q[1] - fall_q[0], 80);

    // even parity, two stop bits
    clear();
    src.push_back(8'hE3);
    fork
      drive(2, 1'b0);
      mon(2, 1, 4, 2, 2);
    join
    chk("frame_8e2", done_q[0] - fall_q[0], 48);

    // odd parity at the minimum baud divisor
    clear();
    src.push_back(8'hE3);
    fork
      drive(3, 1'b0);
      mon(3, 1, 2, 1, 1);
    join
    chk("frame_8o1", done_q[0] - fall_q[0], 22);

    // back-pressure with data scrambled while not ready
    clear();
    src.push_back(8'h11);
    src.push_back(8'h22);
    src.push_back(8'h33);
    fork
      drive(1, 1'b1);
      mon(1, 3, 4, 0, 1);
    join
    chk("q_drained", exp_q.size(), 0);

    // reset during data bit 3 with a second byte held
    clear();
    src.push_back(8'h0F);
    src.push_back(8'hF0);
    drive(1, 1'b0);
    target = acc_q[0] + 1 + 16 + 2;
    while (cyc < target) @(negedge clk);
    chk("pre_busy", int'(bsy[1]), 1);
    chk("pre_held", int'(rdy[1]), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", int'(txo[1]), 1);
    chk("rst_mid_ready", int'(rdy[1]), 1);
    chk("rst_mid_busy", int'(bsy[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txo[1] !== 1'b1 || bsy[1] !== 1'b0) bad++;
    end
    chk("no_frame_after_rst", bad, 0);

    clear();
    src.push_back(8'h5A);
    fork
      drive(1, 1'b0);
      mon(1, 1, 4, 0, 1);
    join
    chk("frame_recover", done_q[0] - fall_q[0], 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
